// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore-decoded datapath strobes, retired-instruction counter, illegal-opcode trap.
// Optional MC_MEM_WAIT_EN adds a mem_ready handshake that stalls FETCH, MEMRD and MEMWR.
//
// state  | meaning
// IDLE   | halted, waiting for run
// FETCH  | read instruction, PC <= PC + 4
// DECODE | decode opcode, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | data memory read
// MEMWB  | load writeback (final)
// MEMWR  | data memory write (final)
// EXEC   | R-type ALU operation
// ALUWB  | R-type writeback (final)
// BRANCH | beq compare and conditional PC update (final)
// JUMP   | PC <= jump target (final)
// ADDIEX | addi ALU operation
// ADDIWB | addi writeback (final)
// TRAP   | illegal opcode, absorbing until reset

module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
`ifdef MC_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             mem_ok;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ok) state_d = S_MEMWB;
      end
      // MEMWR is final but may stall; it only retires once the write is accepted
      S_MEMWR: begin
        if (mem_ok) begin
          retire  = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        retire  = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // Pure state decode: reset drives every strobe low immediately
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_TRAP:   illegal = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver pushes expected per-cycle records, monitor pops and compares.
// Builds with or without MC_MEM_WAIT_EN.

module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam int ST_IDLE   = 0;
  localparam int ST_FETCH  = 1;
  localparam int ST_DECODE = 2;
  localparam int ST_MEMADR = 3;
  localparam int ST_MEMRD  = 4;
  localparam int ST_MEMWB  = 5;
  localparam int ST_MEMWR  = 6;
  localparam int ST_EXEC   = 7;
  localparam int ST_ALUWB  = 8;
  localparam int ST_BRANCH = 9;
  localparam int ST_JUMP   = 10;
  localparam int ST_ADDIEX = 11;
  localparam int ST_ADDIWB = 12;
  localparam int ST_TRAP   = 15;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } strb_t;

  typedef struct packed {
    logic [3:0]       st;
    strb_t            strb;
    logic [CNT_W-1:0] cnt;
    logic             ill;
  } rec_t;

  logic             clk;
  logic             rst;
  logic             run;
  logic [5:0]       opcode;
`ifdef MC_MEM_WAIT_EN
  logic             mem_ready;
`endif
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic             illegal;

  rec_t exp_q[$];
  rec_t mon_rec;
  int   checks = 0;
  int   failures = 0;
  int   retired = 0;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
`ifdef MC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_count(instr_count),
    .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control word each state must present, straight from the state descriptions
  function automatic strb_t ref_strobes(input int st);
    strb_t s;
    s = '0;
    case (st)
      ST_FETCH:  begin s.mem_read = 1; s.ir_write = 1; s.pc_write = 1; s.alu_src_b = 2'b01; end
      ST_DECODE: s.alu_src_b = 2'b11;
      ST_MEMADR: begin s.alu_src_a = 1; s.alu_src_b = 2'b10; end
      ST_MEMRD:  begin s.mem_read = 1; s.i_or_d = 1; end
      ST_MEMWB:  begin s.reg_write = 1; s.mem_to_reg = 1; end
      ST_MEMWR:  begin s.mem_write = 1; s.i_or_d = 1; end
      ST_EXEC:   begin s.alu_src_a = 1; s.alu_op = 2'b10; end
      ST_ALUWB:  begin s.reg_write = 1; s.reg_dst = 1; end
      ST_BRANCH: begin s.alu_src_a = 1; s.alu_op = 2'b01; s.pc_write_cond = 1; s.pc_source = 2'b01; end
      ST_JUMP:   begin s.pc_write = 1; s.pc_source = 2'b10; end
      ST_ADDIEX: begin s.alu_src_a = 1; s.alu_src_b = 2'b10; end
      ST_ADDIWB: s.reg_write = 1;
      default:   s = '0;
    endcase
    return s;
  endfunction

  function automatic rec_t make_rec(input int st);
    rec_t r;
    r.st   = 4'(st);
    r.strb = ref_strobes(st);
    r.cnt  = CNT_W'(retired % (1 << CNT_W));
    r.ill  = (st == ST_TRAP);
    return r;
  endfunction

  function automatic strb_t dut_strobes();
    strb_t s;
    s = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
         mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_rec(input rec_t e);
    chk("state", 32'(state), 32'(e.st));
    chk("strobes", 32'(dut_strobes()), 32'(e.strb));
    chk("instr_count", 32'(instr_count), 32'(e.cnt));
    chk("illegal", 32'(illegal), 32'(e.ill));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_rec = exp_q.pop_front();
        check_rec(mon_rec);
      end
    end
  end

  // Called at a falling edge with inputs already set for this cycle
  task automatic do_cycle(input int st);
    exp_q.push_back(make_rec(st));
    @(negedge clk);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic mem_cycle(input int st, input bit last, input logic run_after);
`ifdef MC_MEM_WAIT_EN
    int w;
    w = $urandom_range(0, 3);
    for (int k = 0; k < w; k++) begin
      run = rbit();
      mem_ready = 1'b0;
      do_cycle(st);
    end
    mem_ready = 1'b1;
`endif
    run = last ? run_after : rbit();
    do_cycle(st);
`ifdef MC_MEM_WAIT_EN
    mem_ready = rbit();
`endif
  endtask

  task automatic run_instr(input logic [5:0] op, input logic run_after);
    int path[$];
    int n_idle;
    opcode = op;
    path.push_back(ST_FETCH);
    path.push_back(ST_DECODE);
    case (op)
      6'b100011: begin path.push_back(ST_MEMADR); path.push_back(ST_MEMRD); path.push_back(ST_MEMWB); end
      6'b101011: begin path.push_back(ST_MEMADR); path.push_back(ST_MEMWR); end
      6'b000000: begin path.push_back(ST_EXEC); path.push_back(ST_ALUWB); end
      6'b001000: begin path.push_back(ST_ADDIEX); path.push_back(ST_ADDIWB); end
      6'b000100: path.push_back(ST_BRANCH);
      6'b000010: path.push_back(ST_JUMP);
      default:   path.push_back(ST_TRAP);
    endcase
    foreach (path[i]) begin
      bit last;
      last = (i == path.size() - 1);
      if (path[i] == ST_FETCH || path[i] == ST_MEMRD || path[i] == ST_MEMWR) begin
        mem_cycle(path[i], last, run_after);
      end else begin
        run = last ? run_after : rbit();
        do_cycle(path[i]);
      end
    end
    if (path[path.size() - 1] != ST_TRAP) begin
      retired++;
      if (!run_after) begin
        n_idle = $urandom_range(1, 3);
        for (int k = 0; k < n_idle; k++) begin
          run = (k == n_idle - 1);
          do_cycle(ST_IDLE);
        end
      end
    end
  endtask

  logic [5:0] legal_ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};

  initial begin
    int guard;
    rst = 1'b0;
    run = 1'b1;
    opcode = 6'd0;
`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b0;
`endif
    @(negedge clk);
    do_cycle(ST_IDLE);
    do_cycle(ST_IDLE);
    rst = 1'b1;
    run = 1'b1;
    do_cycle(ST_IDLE);

    run_instr(6'b100011, 1'b1);
    run_instr(6'b000000, 1'b1);
    run_instr(6'b101011, 1'b1);
    run_instr(6'b000100, 1'b1);
    run_instr(6'b000010, 1'b1);
    run_instr(6'b000000, 1'b0);
    run_instr(6'b001000, 1'b1);

    for (int n = 0; n < 40; n++)
      run_instr(legal_ops[$urandom_range(0, 5)], rbit());

    // Abandon an R-type mid-flight with an asynchronous reset
    opcode = 6'b000000;
    mem_cycle(ST_FETCH, 1'b0, 1'b1);
    run = rbit();
    do_cycle(ST_DECODE);
    run = 1'b1;
    exp_q.push_back(make_rec(ST_EXEC));
    #2;
    rst = 1'b0;
    #1;
    retired = 0;
    check_rec(make_rec(ST_IDLE));
    @(negedge clk);
    do_cycle(ST_IDLE);
    rst = 1'b1;
    run = 1'b1;
    do_cycle(ST_IDLE);

    for (int n = 0; n < 6; n++)
      run_instr(legal_ops[$urandom_range(0, 5)], 1'b1);

    run_instr(6'b111111, 1'b1);
    for (int k = 0; k < 22; k++) begin
      run = rbit();
      opcode = 6'($urandom_range(0, 63));
      do_cycle(ST_TRAP);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      #2;
      guard++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
